// File: rtl/timed_update_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : timed_update_sequencer_if
// Brief    : Run request plus register/status bundle of the timed sequencer.
// Revision : 1.0
// ============================================================================
interface timed_update_sequencer_if #(
    parameter int W  = 32,
    parameter int TW = 16
);
    logic          start;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [W-1:0]  z;
    logic          x_valid;
    logic          y_valid;
    logic          z_valid;
    logic [TW-1:0] t;
    logic          busy;
    logic          done;
    logic          upd;

    modport master (
        input  start,
        output x, y, z, x_valid, y_valid, z_valid, t, busy, done, upd
    );

    modport slave (
        output start,
        input  x, y, z, x_valid, y_valid, z_valid, t, busy, done, upd
    );
endinterface
`default_nettype wire

// File: rtl/timed_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : timed_update_sequencer
// Brief    : Scheduled x/y/z updates sharing x between a periodic incrementer
//            and a one-shot load/derive script.
// Revision : 1.0
// ============================================================================
module timed_update_sequencer #(
    parameter int           W          = 32,
    parameter int           INC_PERIOD = 7,
    parameter int           T_LOAD     = 10,
    parameter int           T_Y        = 10,
    parameter int           T_Z        = 10,
    parameter int           T_FIN      = 1,
    parameter logic [W-1:0] LOAD_VAL   = W'(5),
    parameter int           TW         = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    timed_update_sequencer_if.master bus
);
    localparam logic [TW-1:0] C_T_LOAD = TW'(T_LOAD);
    localparam logic [TW-1:0] C_T_Y    = TW'(T_LOAD + T_Y);
    localparam logic [TW-1:0] C_T_Z    = TW'(T_LOAD + T_Y + T_Z);
    localparam logic [TW-1:0] C_TF     = TW'(T_LOAD + T_Y + T_Z + T_FIN);
    localparam int            C_PW     = (INC_PERIOD > 1) ? $clog2(INC_PERIOD) : 1;
    localparam logic [C_PW-1:0] C_P_LAST = C_PW'(INC_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_t;
    logic [C_PW-1:0] r_pcnt;
    logic [W-1:0]    r_x, r_y, r_z;
    logic            r_xv, r_yv, r_zv;
    logic            r_busy, r_done, r_upd;

    logic [TW-1:0]   w_t_nxt;
    logic            w_inc;
    logic [W-1:0]    w_x_nxt, w_y_nxt, w_z_nxt;
    logic            w_xv_nxt, w_yv_nxt, w_zv_nxt;
    logic            w_run_chg, w_clr_chg;

    assign w_t_nxt = r_t + TW'(1);
    // Phase counter tracks t mod INC_PERIOD so no divider is needed.
    assign w_inc   = (r_pcnt == C_P_LAST);

    always_comb begin
        w_x_nxt  = r_x;
        w_y_nxt  = r_y;
        w_z_nxt  = r_z;
        w_xv_nxt = r_xv;
        w_yv_nxt = r_yv;
        w_zv_nxt = r_zv;
        if (r_state == S_RUN) begin
            // Load has priority over a coinciding increment; y/z use pre-edge operands.
            if (w_t_nxt == C_T_LOAD) begin
                w_x_nxt  = LOAD_VAL;
                w_xv_nxt = 1'b1;
            end else if (w_inc && r_xv) begin
                w_x_nxt = r_x + W'(1);
            end
            if (w_t_nxt == C_T_Y) begin
                w_y_nxt  = r_x + W'(1);
                w_yv_nxt = r_xv;
            end
            if (w_t_nxt == C_T_Z) begin
                w_z_nxt  = r_y + W'(1);
                w_zv_nxt = r_yv;
            end
        end
        w_run_chg = (w_x_nxt != r_x) || (w_y_nxt != r_y) || (w_z_nxt != r_z) ||
                    (w_xv_nxt != r_xv) || (w_yv_nxt != r_yv) || (w_zv_nxt != r_zv);
        w_clr_chg = (r_x != '0) || (r_y != '0) || (r_z != '0) || r_xv || r_yv || r_zv;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_t     <= '0;
            r_pcnt  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_xv    <= 1'b0;
            r_yv    <= 1'b0;
            r_zv    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_upd   <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_t     <= '0;
                        r_pcnt  <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_z     <= '0;
                        r_xv    <= 1'b0;
                        r_yv    <= 1'b0;
                        r_zv    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_upd   <= w_clr_chg;
                    end
                end
                S_RUN: begin
                    r_t    <= w_t_nxt;
                    r_pcnt <= w_inc ? '0 : r_pcnt + C_PW'(1);
                    r_x    <= w_x_nxt;
                    r_y    <= w_y_nxt;
                    r_z    <= w_z_nxt;
                    r_xv   <= w_xv_nxt;
                    r_yv   <= w_yv_nxt;
                    r_zv   <= w_zv_nxt;
                    r_upd  <= w_run_chg;
                    if (w_t_nxt == C_TF) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x       = r_x;
    assign bus.y       = r_y;
    assign bus.z       = r_z;
    assign bus.x_valid = r_xv;
    assign bus.y_valid = r_yv;
    assign bus.z_valid = r_zv;
    assign bus.t       = r_t;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.upd     = r_upd;
endmodule
`default_nettype wire

// File: tb/tb_timed_update_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_timed_update_sequencer
// Brief    : Scoreboard bench for three parameterisations of the sequencer.
// Revision : 1.0
// ============================================================================
module tb_timed_update_sequencer;
    localparam int W  = 32;
    localparam int TW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    timed_update_sequencer_if #(.W(W), .TW(TW)) b0();
    timed_update_sequencer_if #(.W(W), .TW(TW)) b1();
    timed_update_sequencer_if #(.W(W), .TW(TW)) b2();

    timed_update_sequencer #(.W(W), .TW(TW)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    timed_update_sequencer #(.W(W), .TW(TW), .INC_PERIOD(5)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    timed_update_sequencer #(.W(W), .TW(TW), .LOAD_VAL(32'hFFFF_FFFF)) d2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct packed {
        logic [15:0] t;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [2:0]  v;
        logic        busy;
        logic        done;
    } snap_t;

    snap_t q0[$];
    snap_t q1[$];
    snap_t q2[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic snap_t mk(input int tt, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z, input logic [2:0] v);
        snap_t s;
        s = '{16'(tt), x, y, z, v, 1'b1, 1'b0};
        return s;
    endfunction

    task automatic push(input int id, input snap_t s);
        case (id)
            0: q0.push_back(s);
            1: q1.push_back(s);
            default: q2.push_back(s);
        endcase
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_snap(input string name, input snap_t a, input snap_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got t=%0d x=%h y=%h z=%h v=%b busy=%b done=%b, expected t=%0d x=%h y=%h z=%h v=%b busy=%b done=%b",
                     name, a.t, a.x, a.y, a.z, a.v, a.busy, a.done,
                     e.t, e.x, e.y, e.z, e.v, e.busy, e.done);
        end
    endtask

    task automatic unexpected(input string name, input logic [15:0] tt);
        n_tests++;
        n_fail++;
        $display("FAIL %s: upd at t=%0d with nothing expected", name, tt);
    endtask

    // Monitors: every upd pulse pops one expected snapshot.
    always @(negedge clk) begin
        snap_t a;
        if (rst_n && b0.upd) begin
            a = '{b0.t, b0.x, b0.y, b0.z, {b0.x_valid, b0.y_valid, b0.z_valid}, b0.busy, b0.done};
            if (q0.size() == 0) unexpected("d0_upd", b0.t);
            else check_snap("d0_upd", a, q0.pop_front());
        end
    end
    always @(negedge clk) begin
        snap_t a;
        if (rst_n && b1.upd) begin
            a = '{b1.t, b1.x, b1.y, b1.z, {b1.x_valid, b1.y_valid, b1.z_valid}, b1.busy, b1.done};
            if (q1.size() == 0) unexpected("d1_upd", b1.t);
            else check_snap("d1_upd", a, q1.pop_front());
        end
    end
    always @(negedge clk) begin
        snap_t a;
        if (rst_n && b2.upd) begin
            a = '{b2.t, b2.x, b2.y, b2.z, {b2.x_valid, b2.y_valid, b2.z_valid}, b2.busy, b2.done};
            if (q2.size() == 0) unexpected("d2_upd", b2.t);
            else check_snap("d2_upd", a, q2.pop_front());
        end
    end

    task automatic push_default_run();
        push(0, mk(10, 5, 0, 0, 3'b100));
        push(0, mk(14, 6, 0, 0, 3'b100));
        push(0, mk(20, 6, 7, 0, 3'b110));
        push(0, mk(21, 7, 7, 0, 3'b110));
        push(0, mk(28, 8, 7, 0, 3'b110));
        push(0, mk(30, 8, 7, 8, 3'b111));
    endtask

    task automatic wait_done0(input string name);
        int i;
        for (i = 0; i < 100 && !b0.done; i++) @(negedge clk);
        n_tests++;
        if (!b0.done) begin
            n_fail++;
            $display("FAIL %s: done not seen, got done=%b expected 1", name, b0.done);
        end
    endtask

    task automatic check_final0(input string p);
        check_val({p, "_t"}, 32'(b0.t), 31);
        check_val({p, "_busy"}, 32'(b0.busy), 0);
        check_val({p, "_x"}, b0.x, 8);
        check_val({p, "_y"}, b0.y, 7);
        check_val({p, "_z"}, b0.z, 8);
        check_val({p, "_valid"}, 32'({b0.x_valid, b0.y_valid, b0.z_valid}), 7);
    endtask

    initial begin
        b0.start = 1'b0;
        b1.start = 1'b0;
        b2.start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_x", b0.x, 0);
        check_val("rst_t", 32'(b0.t), 0);
        check_val("rst_flags", 32'({b0.busy, b0.done, b0.upd, b0.x_valid, b0.y_valid, b0.z_valid}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        push_default_run();
        push(1, mk(10, 5, 0, 0, 3'b100));
        push(1, mk(15, 6, 0, 0, 3'b100));
        push(1, mk(20, 7, 7, 0, 3'b110));
        push(1, mk(25, 8, 7, 0, 3'b110));
        push(1, mk(30, 9, 7, 8, 3'b111));
        push(2, mk(10, 32'hFFFF_FFFF, 0, 0, 3'b100));
        push(2, mk(14, 0, 0, 0, 3'b100));
        push(2, mk(20, 0, 1, 0, 3'b110));
        push(2, mk(21, 1, 1, 0, 3'b110));
        push(2, mk(28, 2, 1, 0, 3'b110));
        push(2, mk(30, 2, 1, 2, 3'b111));

        // d0 keeps start high through the whole run and into DONE.
        b0.start = 1'b1;
        b1.start = 1'b1;
        b2.start = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        b2.start = 1'b0;
        check_val("start_busy", 32'(b0.busy), 1);
        check_val("start_t", 32'(b0.t), 0);

        wait_done0("run1_done");
        check_final0("run1");
        check_val("d1_x", b1.x, 9);
        check_val("d1_yz", {b1.y[15:0], b1.z[15:0]}, {16'd7, 16'd8});
        check_val("d2_x", b2.x, 2);
        check_val("d2_yz", {b2.y[15:0], b2.z[15:0]}, {16'd1, 16'd2});
        check_val("d12_done", 32'({b1.done, b1.busy, b2.done, b2.busy}), 32'b1010);

        push(0, mk(0, 0, 0, 0, 3'b000));
        push_default_run();
        @(negedge clk);
        check_val("restart_busy", 32'({b0.busy, b0.done}), 32'b10);
        check_val("restart_t", 32'(b0.t), 0);
        b0.start = 1'b0;
        wait_done0("run2_done");
        check_final0("run2");

        // Third run aborted by reset at t = 15.
        push(0, mk(0, 0, 0, 0, 3'b000));
        push(0, mk(10, 5, 0, 0, 3'b100));
        push(0, mk(14, 6, 0, 0, 3'b100));
        b0.start = 1'b1;
        @(negedge clk);
        b0.start = 1'b0;
        for (int i = 0; i < 100 && b0.t != 16'd15; i++) @(negedge clk);
        check_val("reach_t15", 32'(b0.t), 15);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_x", b0.x, 0);
        check_val("abort_t", 32'(b0.t), 0);
        check_val("abort_flags", 32'({b0.busy, b0.done, b0.upd, b0.x_valid, b0.y_valid, b0.z_valid}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("idle_t", 32'(b0.t), 0);
        check_val("idle_flags", 32'({b0.busy, b0.done}), 0);

        check_val("q0_empty", 32'(q0.size()), 0);
        check_val("q1_empty", 32'(q1.size()), 0);
        check_val("q2_empty", 32'(q2.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/timed_update_sequencer.md
# timed_update_sequencer

Hardware sequencer that drives three W-bit state registers (x, y, z) from a cycle-accurate schedule. It shares the single update port of each register between two requesters: a free-running periodic incrementer on x and a one-shot scripted sequence that loads x, derives y from x, and derives z from y. It is the synthesizable controller for the timed register-update datapath used in the lab benches. Its outputs and update strobe feed the team's trace/monitor logic.

## Interface
- W, 32, register width
- INC_PERIOD, 7, cycles between periodic increment requests on x (≥1)
- T_LOAD, 10, time at which x is loaded with LOAD_VAL
- T_Y, 10, delay after T_LOAD at which y ← x+1
- T_Z, 10, delay after y event at which z ← y+1
- T_FIN, 1, delay after z event at which the run finishes
- LOAD_VAL, 5, constant loaded into x
- TW, 16, width of time counter; T_LOAD+T_Y+T_Z+T_FIN < 2^TW required

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level-sampled run request (accepted in IDLE or DONE only)
- x, y, z  out  W each  register values
- x_valid, y_valid, z_valid  out  1 each  register holds a defined value
- t  out  TW  current schedule time
- busy  out  1  state == RUN
- done  out  1  state == DONE
- upd  out  1  any of x/y/z or their valid flags changed at the last edge

## Operation
- States: IDLE → RUN on start; RUN → DONE when t reaches TF = T_LOAD+T_Y+T_Z+T_FIN; DONE → RUN on start. No other transitions.
- Accepting start (the edge into RUN) clears t to 0, all valid flags to 0, and x/y/z to 0. start is ignored in RUN.
- In RUN, t increments by 1 each edge. An event "at time T" is applied on the edge where t becomes T, so the new value is visible while t == T.
- Periodic requester: fires when t becomes a nonzero multiple of INC_PERIOD, from t = INC_PERIOD up to and including TF. It sets x ← x+1 mod 2^W only if x_valid; otherwise the request is dropped.
- Scripted events:
  - t = T_LOAD: x ← LOAD_VAL, x_valid ← 1.
  - t = T_LOAD+T_Y: y ← x+1, y_valid ← x_valid.
  - t = T_LOAD+T_Y+T_Z: z ← y+1, z_valid ← y_valid.
- Arbitration on x: if the load and an increment coincide, the load wins and the increment is discarded.
- Operand sampling: y and z events use the pre-edge register values. A same-edge increment of x does not affect the y computed on that edge.
- All arithmetic is modulo 2^W, with no saturation or flag.
- In DONE, x/y/z, the valid flags and t are frozen and no further increments occur.

## Timing
- Reset (asynchronous, immediate): state = IDLE; x = y = z = 0; all valid flags 0; t = 0; busy = 0; done = 0; upd = 0.
- Reset asserted mid-RUN aborts at once. After release, the block stays in IDLE until start.
- start → busy = 1 after 1 edge.
- Last RUN edge sets t = TF and done = 1 on that same edge; busy drops together.
- upd is a single-cycle registered pulse asserted with the edge that changed any value. It is high for a dropped increment only if something else changed on that edge.
- Restart from DONE: the clearing edge asserts upd if any register or valid flag actually changed.
- No combinational path from inputs to outputs.

## Test plan
- Default parameters, start pulse:
  - t = 7: increment dropped, x_valid = 0.
  - t = 10: x = 5.
  - t = 14: x = 6.
  - t = 20: y = 7.
  - t = 21: x = 7.
  - t = 28: x = 8.
  - t = 30: z = 8.
  - t = 31: done = 1, busy = 0. Final state x = 8, y = 7, z = 8, all valid.
- INC_PERIOD = 5 (collision case):
  - t = 10: x = 5 (load wins).
  - t = 15: x = 6.
  - t = 20: x = 7 and y = 7 (y uses old x = 6).
  - t = 25: x = 8.
  - t = 30: x = 9 and z = 8.
  - Final state x = 9, y = 7, z = 8.
- Wrap-around, LOAD_VAL = 0xFFFF_FFFF:
  - t = 10: x = 0xFFFF_FFFF.
  - t = 14: x = 0.
  - t = 20: y = 1.
  - t = 30: z = 2.
  - Final x = 2.
- rst_n low at t = 15: all outputs go to reset values immediately. After release, state is IDLE and t stays 0 until start.
- start held high through RUN: no restart and the schedule is unaffected. In DONE, a new start clears t and the valids, and the default sequence repeats with identical values.
- upd check: pulses exactly at t = 10, 14, 20, 21, 28, 30 for default parameters, and never at t = 7.
